hazard_ctrl: RTL and testbench

- Central stall/forward controller of the 5-stage pipeline.
- Consumes the D-stage decode attributes: read addresses, write address, Tuse class flags and the 2-bit result class `res`.
- Keeps a shadow pipeline of write-address/Tnew for E, M and W.
- Drives the `stall` line (freeze PC and IF/ID, bubble into ID/EX) and all forwarding-mux selects.

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall and forwarding-select generation for the 5-stage pipeline.
// A shadow pipeline of destination/Tnew for E, M and W sits alongside the datapath.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ra1_d,
  input  logic [4:0] ra2_d,
  input  logic [4:0] wa_d,
  input  logic       tuse_rs0_d,
  input  logic       tuse_rs1_d,
  input  logic       tuse_rt0_d,
  input  logic       tuse_rt1_d,
  input  logic       tuse_rt2_d,
  input  logic [1:0] res_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m
);

  logic [4:0] rs_e, rt_e, wa_e;
  logic [1:0] tnew_e;
  logic [4:0] rt_m, wa_m;
  logic [1:0] tnew_m;
  logic [4:0] wa_w;

  logic [4:0] wa_new;
  logic [1:0] tnew_new;
  logic       rs_used, rt_used;
  logic [1:0] tuse_rs, tuse_rt;
  logic [2:0] rs_d_res, rt_d_res;
  logic       stall_raw;
  logic [1:0] fwd_rs_e_raw, fwd_rt_e_raw;
  logic       fwd_rt_m_raw;

  // Newest producer wins; returns {stall, fwd_sel} for one D-stage source.
  function automatic logic [2:0] d_src(input logic [4:0] a, input logic used,
                                       input logic [1:0] tuse,
                                       input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                       input logic [4:0] m_wa, input logic [1:0] m_tnew,
                                       input logic [4:0] w_wa);
    logic       st;
    logic [1:0] fw;
    st = 1'b0;
    fw = 2'b00;
    if (a != 5'd0) begin
      if (a == e_wa) begin
        st = used && (e_tnew > tuse);
        if (e_tnew == 2'd0) fw = 2'b01;
      end else if (a == m_wa) begin
        st = used && (m_tnew > tuse);
        if (m_tnew == 2'd0) fw = 2'b10;
      end else if (a == w_wa) begin
        fw = 2'b11;
      end
    end
    return {st, fw};
  endfunction

  function automatic logic [1:0] e_src(input logic [4:0] a, input logic [4:0] m_wa,
                                       input logic [1:0] m_tnew, input logic [4:0] w_wa);
    logic [1:0] fw;
    fw = 2'b00;
    if (a != 5'd0) begin
      if (a == m_wa) begin
        if (m_tnew == 2'd0) fw = 2'b10;
      end else if (a == w_wa) begin
        fw = 2'b11;
      end
    end
    return fw;
  endfunction

  always_comb begin
    wa_new = (res_d == 2'b00) ? 5'd0 : wa_d;
    case (res_d)
      2'b01:   tnew_new = 2'd1;
      2'b10:   tnew_new = 2'd2;
      default: tnew_new = 2'd0;
    endcase
  end

  always_comb begin
    rs_used = tuse_rs0_d | tuse_rs1_d;
    tuse_rs = tuse_rs0_d ? 2'd0 : 2'd1;
    rt_used = tuse_rt0_d | tuse_rt1_d | tuse_rt2_d;
    tuse_rt = tuse_rt0_d ? 2'd0 : (tuse_rt1_d ? 2'd1 : 2'd2);
  end

  always_comb begin
    rs_d_res     = d_src(ra1_d, rs_used, tuse_rs, wa_e, tnew_e, wa_m, tnew_m, wa_w);
    rt_d_res     = d_src(ra2_d, rt_used, tuse_rt, wa_e, tnew_e, wa_m, tnew_m, wa_w);
    stall_raw    = rs_d_res[2] | rt_d_res[2];
    fwd_rs_e_raw = e_src(rs_e, wa_m, tnew_m, wa_w);
    fwd_rt_e_raw = e_src(rt_e, wa_m, tnew_m, wa_w);
    fwd_rt_m_raw = (rt_m != 5'd0) && (rt_m == wa_w);
  end

  // M and W always advance; only E takes a bubble on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_e   <= 5'd0;
      rt_e   <= 5'd0;
      wa_e   <= 5'd0;
      tnew_e <= 2'd0;
      rt_m   <= 5'd0;
      wa_m   <= 5'd0;
      tnew_m <= 2'd0;
      wa_w   <= 5'd0;
    end else begin
      if (stall_raw) begin
        rs_e   <= 5'd0;
        rt_e   <= 5'd0;
        wa_e   <= 5'd0;
        tnew_e <= 2'd0;
      end else begin
        rs_e   <= ra1_d;
        rt_e   <= ra2_d;
        wa_e   <= wa_new;
        tnew_e <= tnew_new;
      end
      rt_m   <= rt_e;
      wa_m   <= wa_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      wa_w   <= wa_m;
    end
  end

  always_comb begin
    stall    = 1'b0;
    fwd_rs_d = 2'b00;
    fwd_rt_d = 2'b00;
    fwd_rs_e = 2'b00;
    fwd_rt_e = 2'b00;
    fwd_rt_m = 1'b0;
    if (!reset) begin
      stall    = stall_raw;
      fwd_rs_d = rs_d_res[1:0];
      fwd_rt_d = rt_d_res[1:0];
      fwd_rs_e = fwd_rs_e_raw;
      fwd_rt_e = fwd_rt_e_raw;
      fwd_rt_m = fwd_rt_m_raw;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: hand-derived instruction sequences, then random stimulus
// against a model that tracks each in-flight instruction by its absolute ready cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ra1_d, ra2_d, wa_d;
  logic       tuse_rs0_d, tuse_rs1_d, tuse_rt0_d, tuse_rt1_d, tuse_rt2_d;
  logic [1:0] res_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ra1_d     (ra1_d),
    .ra2_d     (ra2_d),
    .wa_d      (wa_d),
    .tuse_rs0_d(tuse_rs0_d),
    .tuse_rs1_d(tuse_rs1_d),
    .tuse_rt0_d(tuse_rt0_d),
    .tuse_rt1_d(tuse_rt1_d),
    .tuse_rt2_d(tuse_rt2_d),
    .res_d     (res_d),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .fwd_rt_m  (fwd_rt_m)
  );

  typedef struct {
    logic       rst;
    logic [4:0] ra1, ra2, wa;
    logic [4:0] tu;  // {rs0, rs1, rt0, rt1, rt2}
    logic [1:0] res;
    logic       st;
    logic [1:0] frsd, frtd, frse, frte;
    logic       frtm;
  } vec_t;

  vec_t vecs[$];

  // One in-flight instruction: sources, destination and the cycle its result exists.
  typedef struct {
    logic [4:0] rs, rt, wa;
    int         ready;
  } ent_t;

  ent_t hist[$];  // [0]=W, [1]=M, [2]=E
  int   cyc = 0;

  logic       m_stall;
  logic [1:0] m_frsd, m_frtd, m_frse, m_frte;
  logic       m_frtm;

  task automatic add(input logic rst, input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic [4:0] wa, input logic [4:0] tu, input logic [1:0] res,
                     input logic st, input logic [1:0] frsd, input logic [1:0] frtd,
                     input logic [1:0] frse, input logic [1:0] frte, input logic frtm);
    vec_t v;
    v.rst = rst; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.tu = tu; v.res = res;
    v.st = st; v.frsd = frsd; v.frtd = frtd; v.frse = frse; v.frte = frte; v.frtm = frtm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [4:0] wa, input logic [4:0] tu, input logic [1:0] res);
    reset = rst; ra1_d = ra1; ra2_d = ra2; wa_d = wa; res_d = res;
    tuse_rs0_d = tu[4]; tuse_rs1_d = tu[3];
    tuse_rt0_d = tu[2]; tuse_rt1_d = tu[1]; tuse_rt2_d = tu[0];
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] got,
                       input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, want);
    end
  endtask

  function automatic ent_t bubble();
    ent_t b;
    b.rs = 5'd0; b.rt = 5'd0; b.wa = 5'd0; b.ready = 0;
    return b;
  endfunction

  // Newest matching in-flight producer decides; remaining = cycles until its value exists.
  task automatic src_d(input logic [4:0] a, input logic used, input int tuse,
                       output logic st, output logic [1:0] fw);
    st = 1'b0;
    fw = 2'b00;
    if (a != 5'd0) begin
      for (int s = 2; s >= 0; s--) begin
        if (hist[s].wa == a) begin
          int rem = hist[s].ready - cyc;
          st = used && (rem > tuse);
          if (rem <= 0) fw = 2'(3 - s);
          break;
        end
      end
    end
  endtask

  task automatic src_e(input logic [4:0] a, output logic [1:0] fw);
    fw = 2'b00;
    if (a != 5'd0) begin
      if (hist[1].wa == a) begin
        if (hist[1].ready - cyc <= 0) fw = 2'b10;
      end else if (hist[0].wa == a) begin
        fw = 2'b11;
      end
    end
  endtask

  logic raw_stall;

  task automatic model_eval();
    logic st_rs, st_rt;
    src_d(ra1_d, tuse_rs0_d | tuse_rs1_d, tuse_rs0_d ? 0 : 1, st_rs, m_frsd);
    src_d(ra2_d, tuse_rt0_d | tuse_rt1_d | tuse_rt2_d,
          tuse_rt0_d ? 0 : (tuse_rt1_d ? 1 : 2), st_rt, m_frtd);
    src_e(hist[2].rs, m_frse);
    src_e(hist[2].rt, m_frte);
    m_frtm    = (hist[1].rt != 5'd0) && (hist[1].rt == hist[0].wa);
    raw_stall = st_rs | st_rt;
    m_stall   = raw_stall;
    if (reset) begin
      m_stall = 1'b0; m_frsd = 2'b00; m_frtd = 2'b00;
      m_frse  = 2'b00; m_frte = 2'b00; m_frtm = 1'b0;
    end
  endtask

  task automatic model_advance();
    ent_t n;
    cyc++;
    if (reset) begin
      hist.delete();
      repeat (3) hist.push_back(bubble());
    end else begin
      n = bubble();
      if (!raw_stall && res_d != 2'b00) begin
        n.wa    = wa_d;
        n.ready = cyc + ((res_d == 2'b01) ? 1 : (res_d == 2'b10) ? 2 : 0);
      end
      if (!raw_stall) begin
        n.rs = ra1_d;
        n.rt = ra2_d;
      end
      hist.push_back(n);
      void'(hist.pop_front());
    end
  endtask

  // idx >= 0: compare against table row; idx < 0: compare against the model.
  task automatic run_cycle(input int idx);
    @(negedge clk);
    model_eval();
    if (idx >= 0) begin
      check("stall",    idx, {1'b0, stall},    {1'b0, vecs[idx].st});
      check("fwd_rs_d", idx, fwd_rs_d,         vecs[idx].frsd);
      check("fwd_rt_d", idx, fwd_rt_d,         vecs[idx].frtd);
      check("fwd_rs_e", idx, fwd_rs_e,         vecs[idx].frse);
      check("fwd_rt_e", idx, fwd_rt_e,         vecs[idx].frte);
      check("fwd_rt_m", idx, {1'b0, fwd_rt_m}, {1'b0, vecs[idx].frtm});
    end else begin
      check("rnd_stall",    cyc, {1'b0, stall},    {1'b0, m_stall});
      check("rnd_fwd_rs_d", cyc, fwd_rs_d,         m_frsd);
      check("rnd_fwd_rt_d", cyc, fwd_rt_d,         m_frtd);
      check("rnd_fwd_rs_e", cyc, fwd_rs_e,         m_frse);
      check("rnd_fwd_rt_e", cyc, fwd_rt_e,         m_frte);
      check("rnd_fwd_rt_m", cyc, {1'b0, fwd_rt_m}, {1'b0, m_frtm});
    end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    repeat (3) hist.push_back(bubble());
    // reset with live D inputs, then first cycle out of reset
    add(1, 8, 8, 8, 5'b11111, 2'b10, 0, 0, 0, 0, 0, 0);
    add(1, 8, 8, 8, 5'b11111, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 8, 9, 0, 5'b10100, 2'b00, 0, 0, 0, 0, 0, 0);
    // lw $8 ; addu $9,$8,$1 (rs in E): one stall, then W forwards into E
    add(0, 0, 0, 8, 5'b00000, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 8, 1, 9, 5'b01010, 2'b01, 1, 0, 0, 0, 0, 0);
    add(0, 8, 1, 9, 5'b01010, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 2'b11, 0, 0);
    // lw $8 ; beq $8,$0 (rs in D): two stalls, then W forwards into D
    add(0, 0, 0, 8, 5'b00000, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 8, 0, 0, 5'b10100, 2'b00, 1, 0, 0, 0, 0, 0);
    add(0, 8, 0, 0, 5'b10100, 2'b00, 1, 0, 0, 0, 0, 0);
    add(0, 8, 0, 0, 5'b10100, 2'b00, 0, 2'b11, 0, 0, 0, 0);
    // addu $8 ; sw $8,0($2) (rt in M): no stall, M forwards into E
    add(0, 0, 0, 8, 5'b00000, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 2, 8, 0, 5'b01001, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0, 2'b10, 0);
    add(0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0, 0, 1);
    // jal ; jr $31 ; ori $0 ; addu using $0
    add(0, 0, 0, 31, 5'b00000, 2'b11, 0, 0, 0, 0, 0, 0);
    add(0, 31, 0, 0, 5'b10000, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'b01000, 2'b01, 0, 0, 0, 2'b10, 0, 0);
    add(0, 0, 0, 9, 5'b01010, 2'b01, 0, 0, 0, 0, 0, 0);
    // addu $8 ; addu $8 ; addu $9,$8: newest (E) match, no stall
    add(0, 0, 0, 8, 5'b00000, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8, 5'b00000, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 8, 0, 9, 5'b01010, 2'b01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 2'b10, 0, 0);
    // lw/beq with reset during the second stall cycle
    add(0, 0, 0, 8, 5'b00000, 2'b10, 0, 0, 0, 0, 0, 0);
    add(0, 8, 0, 0, 5'b10100, 2'b00, 1, 0, 0, 0, 0, 0);
    add(1, 8, 0, 0, 5'b10100, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 8, 0, 0, 5'b10100, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 5'b00000, 2'b00);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ra1, vecs[i].ra2, vecs[i].wa, vecs[i].tu, vecs[i].res);
      run_cycle(i);
    end

    // Small address range keeps producer/consumer collisions frequent.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), 2'($urandom));
      run_cycle(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
